vectadd_result_stage: RTL and testbench
=======================================

Name: vectadd_result_stage

Overview:
- Buffers result words from the vector-add datapath and presents them to software through two PIO input ports.
- out_data drives the to_sw_data PIO in_port; out_status drives a status PIO.
- Software advances the queue by flipping one bit of a from_sw PIO output (pop_toggle). Completion is confirmed by an ack bit echoed in out_status.
- Sits directly upstream of the to_sw_data PIO, in the same clock domain.

Parameters:
- DATA_WIDTH, 32, width of result words and of out_data.
- DEPTH, 8, FIFO entries; must be a power of two, 2..128.
- ADDR_WIDTH, 3, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- res_valid  input  1  datapath result valid.
- res_data  input  DATA_WIDTH  datapath result word.
- res_ready  output  1  stage accepts res_data this cycle.
- pop_toggle  input  1  from_sw PIO bit; each level change requests one pop.
- clear  input  1  from_sw PIO bit; level-sensitive synchronous flush.
- out_data  output  DATA_WIDTH  head-of-queue word to the to_sw_data in_port; 0 when empty.
- out_status  output  32  bit0 not_empty, bit1 full, bit2 underflow (sticky), bits[15:8] count (zero-extended), bit16 pop_ack, all other bits 0.

Behaviour:
- Reset (async assert, sync deassert by system): memory content don't-care. wr_ptr=rd_ptr=0, count=0, out_data=0, out_status=0, res_ready=0, pop_q=0, underflow=0.
- Push: occurs when res_valid && res_ready at a rising edge. Writes mem[wr_ptr]; wr_ptr increments modulo DEPTH. The producer must hold res_data/res_valid until accepted.
- res_ready is registered: the value is (next_count < DEPTH) && !clear.
  - It is 1 from the first edge after reset release.
  - It drops to 0 the cycle after the push that fills the FIFO.
  - A push is never lost.
- Pop request:
  - pop_q <= pop_toggle every cycle.
  - pop_req = pop_toggle ^ pop_q, one cycle wide per toggle.
  - If count>0: rd_ptr increments modulo DEPTH and count decrements.
  - If count==0: no pointer change and underflow <= 1.
- pop_ack (status bit16) equals pop_q. It is valid once the pop effect is visible on out_data/out_status. Software polls until bit16 equals the value it wrote.
- Simultaneous push and pop, count>0: count unchanged, both pointers advance.
- Simultaneous push and pop with count==1: out_data becomes the pushed word next cycle.
- Push and pop on an empty FIFO in the same cycle: the push is taken, the pop counts as underflow, and count becomes 1.
- Full and pop in the same cycle: no push, since res_ready=0. res_ready rises the following cycle.
- out_data/out_status are registered from next state. One cycle after the edge that changed the state, they reflect head word, count and flags. out_data=0 whenever next_count==0.
- clear=1 at an edge:
  - Pointers, count and out_data go to 0, and underflow goes to 0.
  - res_ready goes to 0; pushes are ignored while clear is high.
  - pop_q still tracks pop_toggle, so the ack still echoes; pop_req is ignored.
  - Normal operation resumes on the first edge with clear=0. res_ready returns to 1 one cycle later.
- count width is ADDR_WIDTH+1 and counts 0..DEPTH inclusive. Pointers wrap naturally at 2^ADDR_WIDTH.
- Reset asserted mid-operation: immediate return to reset values regardless of state. Queued data is discarded.

Test Plan:
- Reset, then push 0x11111111, 0x22222222, 0x33333333 back-to-back:
  - out_data=0x11111111 one cycle after the first push.
  - out_status=0x00000301 after the third.
  - res_ready held 1 throughout.
- Toggle pop_toggle 0->1, wait for ack bit16=1:
  - out_data=0x22222222, count=2.
  - Toggle 1->0: out_data=0x33333333, bit16=0.
  - Toggle again: out_data=0, out_status=0x00010000.
- Push 8 words 0xA0..0xA7 with res_valid held high, then offer a 9th:
  - res_ready=0 after the 8th; status=0x00000802; the 9th is held.
  - One pop gives res_ready=1 the next cycle; the 9th is accepted and out_data=0xA1.
  - Draining yields 0xA1..0xA7 then the 9th word, confirming pointer wrap.
- With count==1 (head 0x5), push 0x6 and toggle pop in the same cycle: count stays 1, out_data=0x6.
- On an empty FIFO, toggle pop: underflow bit2=1, ack echoes, count=0. Then pulse clear for one cycle: bit2=0, res_ready=0 for that cycle plus one.
- With 4 words queued, assert reset_n=0 asynchronously mid-cycle: all outputs go to 0 immediately. After release: res_ready=1 on the next edge, empty.

Source files
------------

// File: rtl/vectadd_result_stage.sv
// Result FIFO between the vector-add datapath and the software-facing PIO ports.
// Latency: a word accepted at an edge is visible on out_data one cycle later; pop effects likewise.
// Backpressure: res_ready is registered and drops when the FIFO is full or clear is held high.
module vectadd_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  res_valid,
  input  logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_ready,
  input  logic                  pop_toggle,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [31:0]           out_status
);

  localparam logic [ADDR_WIDTH:0] DepthC = (ADDR_WIDTH+1)'(DEPTH);

  // Storage has no reset: contents are don't-care until written.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  underflow_q, underflow_d;
  logic                  pop_q, pop_q_d;
  logic                  res_ready_q, res_ready_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [31:0]           out_status_q, out_status_d;

  logic push;
  logic pop_req;
  logic pop_ok;
  logic bypass;

  // Next-state for pointers, occupancy, flags and the registered output view.
  always_comb begin
    pop_req      = pop_toggle ^ pop_q;
    push         = res_valid && res_ready_q && !clear;
    pop_ok       = pop_req && (count_q != '0) && !clear;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    underflow_d  = underflow_q;
    pop_q_d      = pop_toggle;   // ack echo keeps tracking even during clear
    bypass       = 1'b0;
    out_data_d   = '0;
    out_status_d = '0;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Pop is judged against the occupancy before this edge's push.
      if (pop_req && (count_q == '0)) begin
        underflow_d = 1'b1;
      end
      count_d = count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop_ok};
    end

    res_ready_d = (count_d < DepthC) && !clear;

    // The new head may be the word being written this edge (empty, or
    // count==1 with a pop); memory is not updated yet, so forward it.
    bypass = push && (rd_ptr_d == wr_ptr_q);
    if (count_d != '0) begin
      out_data_d = bypass ? res_data : mem_q[rd_ptr_d];
    end

    out_status_d[0]    = (count_d != '0);
    out_status_d[1]    = (count_d == DepthC);
    out_status_d[2]    = underflow_d;
    out_status_d[15:8] = 8'(count_d);
    out_status_d[16]   = pop_q_d;
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      underflow_q  <= 1'b0;
      pop_q        <= 1'b0;
      res_ready_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      underflow_q  <= underflow_d;
      pop_q        <= pop_q_d;
      res_ready_q  <= res_ready_d;
      out_data_q   <= out_data_d;
      out_status_q <= out_status_d;
    end
  end

  // Word storage written on each accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= res_data;
    end
  end

  assign res_ready  = res_ready_q;
  assign out_data   = out_data_q;
  assign out_status = out_status_q;

endmodule

// File: tb/tb_vectadd_result_stage.sv
// Bench for vectadd_result_stage: directed scenarios then random traffic.
// Reference is a word queue updated once per clock edge from the pin-level rules.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_vectadd_result_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic          res_ready;
  logic          pop_toggle;
  logic          clear;
  logic [DW-1:0] out_data;
  logic [31:0]   out_status;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  bit            m_unf;
  bit            m_ack;
  bit            m_ready;

  vectadd_result_stage #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .res_valid  (res_valid),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .pop_toggle (pop_toggle),
    .clear      (clear),
    .out_data   (out_data),
    .out_status (out_status)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_unf   = 1'b0;
    m_ack   = 1'b0;
    m_ready = 1'b0;
  endtask

  // One rising edge as seen by software and the producer.
  task automatic model_edge();
    bit pop_req;
    bit push;
    pop_req = (pop_toggle != m_ack);
    push    = res_valid && m_ready && !clear;
    if (clear) begin
      mq.delete();
      m_unf = 1'b0;
    end else begin
      if (pop_req) begin
        if (mq.size() > 0) void'(mq.pop_front());
        else m_unf = 1'b1;
      end
      if (push) mq.push_back(res_data);
    end
    m_ack   = pop_toggle;
    m_ready = (mq.size() < DEPTH) && !clear;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_d;
    logic [31:0] exp_s;
    exp_d = (mq.size() > 0) ? mq[0] : 32'h0;
    exp_s = 32'h0;
    exp_s[0]    = (mq.size() > 0);
    exp_s[1]    = (mq.size() == DEPTH);
    exp_s[2]    = m_unf;
    exp_s[15:8] = 8'(mq.size());
    exp_s[16]   = m_ack;
    chk({tag, ".rdy"},  {31'b0, res_ready}, {31'b0, m_ready});
    chk({tag, ".data"}, out_data, exp_d);
    chk({tag, ".stat"}, out_status, exp_s);
  endtask

  task automatic cycle(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Hold a word until the DUT accepts it, with a bounded wait.
  task automatic push_word(input logic [DW-1:0] w);
    bit accepted;
    accepted  = 1'b0;
    res_valid = 1'b1;
    res_data  = w;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = res_ready && !clear;
      cycle("push");
    end
    res_valid = 1'b0;
    chk("push_accept", {31'b0, accepted}, 32'h1);
  endtask

  task automatic pop_one(input string tag);
    pop_toggle = ~pop_toggle;
    cycle(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    res_valid  = 1'b0;
    res_data   = '0;
    pop_toggle = 1'b0;
    clear      = 1'b0;
    model_reset();
    #3;
    chk("rst.rdy",  {31'b0, res_ready}, 32'h0);
    chk("rst.data", out_data, 32'h0);
    chk("rst.stat", out_status, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle("rel");
    chk("rel.rdy1", {31'b0, res_ready}, 32'h1);

    // Three back-to-back pushes
    push_word(32'h1111_1111);
    chk("first_head", out_data, 32'h1111_1111);
    push_word(32'h2222_2222);
    push_word(32'h3333_3333);
    chk("three_stat", out_status, 32'h0000_0301);

    // Pop sequence with ack echo
    pop_one("pop1");
    chk("pop1.ack", {31'b0, out_status[16]}, 32'h1);
    pop_one("pop2");
    pop_one("pop3");
    chk("pop3.stat", out_status, 32'h0001_0000);

    // Fill to full, offer a ninth word, pop once, drain to confirm wrap
    for (int i = 0; i < DEPTH; i++) push_word(32'hA0 + 32'(i));
    chk("full.rdy", {31'b0, res_ready}, 32'h0);
    res_valid = 1'b1;
    res_data  = 32'hB9;
    cycle("held9");
    pop_one("full_pop");
    chk("full_pop.rdy", {31'b0, res_ready}, 32'h1);
    cycle("take9");
    res_valid = 1'b0;
    chk("take9.head", out_data, 32'hA1);
    for (int i = 0; i < DEPTH; i++) pop_one("drain");

    // Push and pop together with one word queued
    push_word(32'h5);
    res_valid = 1'b1;
    res_data  = 32'h6;
    pop_one("pp1");
    res_valid = 1'b0;
    chk("pp1.head", out_data, 32'h6);
    pop_one("pp1_empty");

    // Underflow then a one-cycle clear
    pop_one("unf");
    chk("unf.bit", {31'b0, out_status[2]}, 32'h1);
    clear = 1'b1;
    cycle("clr");
    clear = 1'b0;
    chk("clr.rdy", {31'b0, res_ready}, 32'h0);
    cycle("clr_after");

    // Asynchronous reset with data queued
    for (int i = 0; i < 4; i++) push_word(32'hC0 + 32'(i));
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst.rdy",  {31'b0, res_ready}, 32'h0);
    chk("arst.data", out_data, 32'h0);
    chk("arst.stat", out_status, 32'h0);
    pop_toggle = 1'b0;
    #2;
    reset_n = 1'b1;
    cycle("arst_rel");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      res_valid = ($urandom_range(0, 2) != 0);
      res_data  = $urandom;
      if ($urandom_range(0, 2) == 0) pop_toggle = ~pop_toggle;
      clear = ($urandom_range(0, 39) == 0);
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
